code25_serial_tx: RTL and testbench
===================================

CODE25_SERIAL_TX -- requirements
Module: code25_serial_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, SHALL set clock cycles per serial bit (legal range 1..255).
REQ-002 clk  input  1  SHALL be the single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 digit_i  input  4  SHALL carry a BCD digit to encode.
REQ-005 valid_i  input  1  SHALL mark digit_i as valid.
REQ-006 ready_o  output  1  SHALL indicate the block can accept a digit.
REQ-007 code_o  output  5  SHALL hold the last encoded 2-of-5 word; bit 4 = E1 ... bit 0 = E5.
REQ-008 tx_o  output  1  SHALL be the serial line (idle high).
REQ-009 busy_o  output  1  SHALL be high while a frame is on tx_o.
REQ-010 err_o  output  1  SHALL pulse one cycle on an accepted non-BCD digit.

Function
REQ-011 Encoding (E1..E5) SHALL be: 0=11000, 1=10010, 2=01001, 3=00110, 4=10001, 5=00011, 6=01010, 7=00101, 8=01100, 9=10100; every valid word has exactly two ones.
REQ-012 Handshake: transfer SHALL occur on a rising edge with valid_i && ready_o; ready_o SHALL be high only in IDLE.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE -> START on transfer of digit 0..9; code_o SHALL update on the transfer edge.
REQ-015 On transfer of digit 10..15: state SHALL stay IDLE, code_o unchanged, err_o high for exactly the following cycle, ready_o stays high.
REQ-016 START: tx_o = 0 for CLKS_PER_BIT cycles, then -> DATA.
REQ-017 DATA: tx_o SHALL present E1 first through E5, each for CLKS_PER_BIT cycles; a 3-bit index SHALL count 0..4, then -> STOP.
REQ-018 STOP: tx_o = 1 for CLKS_PER_BIT cycles, then -> IDLE.
REQ-019 Frame SHALL last exactly 7*CLKS_PER_BIT cycles; tx_o SHALL go low the cycle after the transfer edge.
REQ-020 busy_o SHALL be high in START, DATA, STOP; low in IDLE.
REQ-021 Back-to-back: with valid_i held high, the next transfer SHALL occur on the first IDLE cycle, giving one idle-high cycle between frames.
REQ-022 tx_o, busy_o, ready_o, err_o SHALL be registered outputs (no combinational path from inputs).
REQ-023 The bit-period counter SHALL reload to 0 on each bit boundary; CLKS_PER_BIT = 1 SHALL yield one cycle per bit.
REQ-024 digit_i/valid_i changes while busy SHALL have no effect on the frame in progress.

Reset
REQ-025 On rst_n low, immediately: state IDLE, tx_o 1, busy_o 0, ready_o 1, err_o 0, code_o 00000, counters 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; tx_o SHALL return high asynchronously.
REQ-027 First transfer SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-028 A shared package code25_pkg SHALL hold the FSM state enum, the 10-entry encoding table, and constant FRAME_BITS = 7.
REQ-029 Encoding SHALL live in sub-module code25_encoder (combinational: digit 4 -> code 5 plus invalid flag), reusable by other blocks.
REQ-030 No other sub-modules.

Verification
REQ-031 Reset then digit 5 with valid_i, CLKS_PER_BIT=4 -> code_o=00011; tx_o = 0 x4, 0,0,0,1,1 each x4, 1 x4; busy_o high 28 cycles.
REQ-032 Digit 12 accepted in IDLE -> err_o high one cycle, tx_o stays 1, code_o unchanged, busy_o 0.
REQ-033 valid_i held high with digits 0 then 9 -> two frames (11000, 10100) separated by exactly one idle-high cycle.
REQ-034 rst_n pulsed low mid-DATA of digit 8 -> tx_o 1 and busy_o 0 during reset; next digit 3 sends 00110 cleanly.
REQ-035 CLKS_PER_BIT=1, digit 2 -> tx_o sequence 0,0,1,0,0,1,1 over 7 cycles.
REQ-036 Sweep all digits 0..15 -> code_o matches table for 0..9, each with popcount 2; 10..15 raise err_o only.

Source files
------------

// File: rtl/code25_pkg.sv
// Shared definitions for the 2-of-5 serial transmitter: FSM states, the
// digit-to-code table and frame length in bit periods.
package code25_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_e;

  // start + five code bits + stop
  localparam int FRAME_BITS = 7;

  // Entry n is the E1..E5 word for digit n, E1 in bit 4.
  localparam logic [4:0] CODE_TABLE [10] = '{
    5'b11000, 5'b10010, 5'b01001, 5'b00110, 5'b10001,
    5'b00011, 5'b01010, 5'b00101, 5'b01100, 5'b10100
  };

  // Serial order is E1 first, so index 0 maps to the MSB of the code word.
  function automatic logic pick_bit(input logic [4:0] code, input logic [2:0] idx);
    logic b;
    case (idx)
      3'd0:    b = code[4];
      3'd1:    b = code[3];
      3'd2:    b = code[2];
      3'd3:    b = code[1];
      3'd4:    b = code[0];
      default: b = 1'b1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/code25_encoder.sv
// Combinational BCD to 2-of-5 encoder; flags digits 10..15 as invalid and
// returns an all-zero code for them.
module code25_encoder
  import code25_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [4:0] code_o,
  output logic       invalid_o
);

  always_comb begin
    code_o    = 5'b00000;
    invalid_o = 1'b1;
    if (digit_i <= 4'd9) begin
      code_o    = CODE_TABLE[digit_i];
      invalid_o = 1'b0;
    end
  end

endmodule

// File: rtl/code25_serial_tx.sv
// Accepts one BCD digit per frame, encodes it as 2-of-5 and shifts it out as
// start(0), E1..E5, stop(1), each bit lasting CLKS_PER_BIT clocks.
module code25_serial_tx
  import code25_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic [4:0] code_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [4:0] code_q, code_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;
  logic       err_q, err_d;

  logic [4:0] enc_code;
  logic       enc_invalid;
  logic       transfer;
  logic       bit_end;

  code25_encoder u_encoder (
    .digit_i  (digit_i),
    .code_o   (enc_code),
    .invalid_o(enc_invalid)
  );

  // ready_q is only ever high in IDLE, so this also qualifies the state.
  assign transfer = valid_i && ready_q;
  assign bit_end  = (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? 8'd0 : 8'(cnt_q + 8'd1);
    idx_d   = idx_q;
    code_d  = code_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    ready_d = ready_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 8'd0;
        idx_d = 3'd0;
        if (transfer) begin
          if (enc_invalid) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_START;
            code_d  = enc_code;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            ready_d = 1'b0;
          end
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
          tx_d    = pick_bit(code_q, 3'd0);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd4) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = pick_bit(code_q, idx_q + 3'd1);
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
        idx_d   = 3'd0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      code_q  <= 5'b00000;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign ready_o = ready_q;
  assign code_o  = code_q;
  assign tx_o    = tx_q;
  assign busy_o  = busy_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_code25_serial_tx.sv
// Self-checking bench for code25_serial_tx: a queue-based frame model is
// compared cycle by cycle against a CLKS_PER_BIT=4 and a CLKS_PER_BIT=1 instance.
module tb_code25_serial_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] digit, digit1;
  logic       valid, valid1;
  logic       ready, tx, busy, err;
  logic [4:0] code;
  logic       ready1, tx1, busy1, err1;
  logic [4:0] code1;

  int checks = 0;
  int errors = 0;

  logic [4:0] ref_code [10] = '{
    5'b11000, 5'b10010, 5'b01001, 5'b00110, 5'b10001,
    5'b00011, 5'b01010, 5'b00101, 5'b01100, 5'b10100
  };
  bit         exp_q[$];
  logic [4:0] last_code;

  always #5 clk = ~clk;

  code25_serial_tx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .digit_i(digit), .valid_i(valid),
    .ready_o(ready), .code_o(code), .tx_o(tx), .busy_o(busy), .err_o(err)
  );

  code25_serial_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .digit_i(digit1), .valid_i(valid1),
    .ready_o(ready1), .code_o(code1), .tx_o(tx1), .busy_o(busy1), .err_o(err1)
  );

  // Expected tx waveform: c lows, then E1..E5 each c times, then c highs.
  function automatic void build_frame(input int d, input int c);
    exp_q.delete();
    for (int i = 0; i < c; i++) exp_q.push_back(1'b0);
    for (int b = 4; b >= 0; b--)
      for (int i = 0; i < c; i++) exp_q.push_back(ref_code[d][b]);
    for (int i = 0; i < c; i++) exp_q.push_back(1'b1);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; digit = 4'd0; valid1 = 1'b0; digit1 = 4'd0;
    repeat (2) @(negedge clk);
    checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
    checks++; if (err !== 1'b0)   begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (code !== 5'b0)  begin errors++; $display("FAIL reset_code: got %b expected 00000", code); end
    $display("reset: outputs sampled while rst_n low");
  endtask

  // Release reset and present digit 5 in the same cycle: transfer on first edge.
  task automatic test_first_frame();
    rst_n = 1'b1; digit = 4'd5; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    build_frame(5, 4);
    checks++; if (code !== 5'b00011) begin errors++; $display("FAIL first_code: got %b expected 00011", code); end
    for (int i = 0; i < 28; i++) begin
      checks++; if (tx !== exp_q[i]) begin errors++; $display("FAIL first_tx[%0d]: got %b expected %b", i, tx, exp_q[i]); end
      checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL first_busy[%0d]: got %b expected 1", i, busy); end
      @(negedge clk);
    end
    checks++; if (busy !== 1'b0 || tx !== 1'b1 || ready !== 1'b1)
      begin errors++; $display("FAIL first_idle: got busy=%b tx=%b ready=%b expected 0 1 1", busy, tx, ready); end
    last_code = 5'b00011;
    $display("first_frame: digit 5 sent");
  endtask

  task automatic test_invalid();
    for (int k = 0; k < 4; k++) begin
      logic [3:0] d;
      d = (k == 0) ? 4'd12 : 4'($urandom_range(10, 15));
      digit = d; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      checks++; if (err !== 1'b1)       begin errors++; $display("FAIL inv_err d=%0d: got %b expected 1", d, err); end
      checks++; if (tx !== 1'b1)        begin errors++; $display("FAIL inv_tx d=%0d: got %b expected 1", d, tx); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL inv_busy d=%0d: got %b expected 0", d, busy); end
      checks++; if (ready !== 1'b1)     begin errors++; $display("FAIL inv_ready d=%0d: got %b expected 1", d, ready); end
      checks++; if (code !== last_code) begin errors++; $display("FAIL inv_code d=%0d: got %b expected %b", d, code, last_code); end
      @(negedge clk);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL inv_err_clear d=%0d: got %b expected 0", d, err); end
      $display("invalid: digit %0d rejected", d);
    end
  endtask

  task automatic test_back_to_back();
    digit = 4'd0; valid = 1'b1;
    @(negedge clk);
    digit = 4'd9;
    build_frame(0, 4);
    checks++; if (code !== 5'b11000) begin errors++; $display("FAIL b2b_code0: got %b expected 11000", code); end
    for (int i = 0; i < 28; i++) begin
      checks++; if (tx !== exp_q[i]) begin errors++; $display("FAIL b2b_tx0[%0d]: got %b expected %b", i, tx, exp_q[i]); end
      @(negedge clk);
    end
    checks++; if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1)
      begin errors++; $display("FAIL b2b_gap: got tx=%b busy=%b ready=%b expected 1 0 1", tx, busy, ready); end
    @(negedge clk);
    valid = 1'b0;
    build_frame(9, 4);
    checks++; if (code !== 5'b10100) begin errors++; $display("FAIL b2b_code9: got %b expected 10100", code); end
    for (int i = 0; i < 28; i++) begin
      checks++; if (tx !== exp_q[i]) begin errors++; $display("FAIL b2b_tx9[%0d]: got %b expected %b", i, tx, exp_q[i]); end
      checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL b2b_busy9[%0d]: got %b expected 1", i, busy); end
      @(negedge clk);
    end
    last_code = 5'b10100;
    $display("back_to_back: digits 0 and 9 sent");
  endtask

  task automatic test_reset_mid_frame();
    digit = 4'd8; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (17) @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_tx_before: got %b expected 0", tx); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (tx !== 1'b1)    begin errors++; $display("FAIL mid_rst_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b expected 1", ready); end
    checks++; if (code !== 5'b0)  begin errors++; $display("FAIL mid_rst_code: got %b expected 00000", code); end
    @(negedge clk);
    rst_n = 1'b1; digit = 4'd3; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    build_frame(3, 4);
    checks++; if (code !== 5'b00110) begin errors++; $display("FAIL mid_code3: got %b expected 00110", code); end
    for (int i = 0; i < 28; i++) begin
      checks++; if (tx !== exp_q[i]) begin errors++; $display("FAIL mid_tx3[%0d]: got %b expected %b", i, tx, exp_q[i]); end
      @(negedge clk);
    end
    last_code = 5'b00110;
    $display("reset_mid_frame: digit 8 aborted, digit 3 sent");
  endtask

  task automatic test_one_clk();
    for (int k = 0; k < 5; k++) begin
      int d;
      d = (k == 0) ? 2 : int'($urandom_range(0, 9));
      digit1 = 4'(d); valid1 = 1'b1;
      @(negedge clk);
      valid1 = 1'b0;
      build_frame(d, 1);
      checks++; if (code1 !== ref_code[d]) begin errors++; $display("FAIL c1_code d=%0d: got %b expected %b", d, code1, ref_code[d]); end
      for (int i = 0; i < 7; i++) begin
        checks++; if (tx1 !== exp_q[i]) begin errors++; $display("FAIL c1_tx d=%0d [%0d]: got %b expected %b", d, i, tx1, exp_q[i]); end
        checks++; if (busy1 !== 1'b1)   begin errors++; $display("FAIL c1_busy d=%0d [%0d]: got %b expected 1", d, i, busy1); end
        @(negedge clk);
      end
      checks++; if (busy1 !== 1'b0 || ready1 !== 1'b1 || tx1 !== 1'b1 || err1 !== 1'b0)
        begin errors++; $display("FAIL c1_idle d=%0d: got busy=%b ready=%b tx=%b err=%b", d, busy1, ready1, tx1, err1); end
      $display("one_clk: digit %0d sent", d);
    end
  endtask

  // Digits 0..15 in order, then random ones, with random input noise while busy.
  task automatic test_sweep();
    for (int k = 0; k < 24; k++) begin
      int d;
      d = (k < 16) ? k : int'($urandom_range(0, 15));
      digit = 4'(d); valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      if (d < 10) begin
        build_frame(d, 4);
        checks++; if (code !== ref_code[d]) begin errors++; $display("FAIL sw_code d=%0d: got %b expected %b", d, code, ref_code[d]); end
        checks++; if ($countones(code) != 2) begin errors++; $display("FAIL sw_pop d=%0d: got %0d expected 2", d, $countones(code)); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL sw_err d=%0d: got %b expected 0", d, err); end
        for (int i = 0; i < 28; i++) begin
          checks++; if (tx !== exp_q[i]) begin errors++; $display("FAIL sw_tx d=%0d [%0d]: got %b expected %b", d, i, tx, exp_q[i]); end
          checks++; if (busy !== 1'b1)   begin errors++; $display("FAIL sw_busy d=%0d [%0d]: got %b expected 1", d, i, busy); end
          digit = 4'($urandom_range(0, 15));
          valid = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        valid = 1'b0;
        last_code = ref_code[d];
        checks++; if (busy !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL sw_idle d=%0d: got busy=%b ready=%b", d, busy, ready); end
      end else begin
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL sw_inv d=%0d: got err=%b busy=%b expected 1 0", d, err, busy); end
        checks++; if (code !== last_code) begin errors++; $display("FAIL sw_inv_code d=%0d: got %b expected %b", d, code, last_code); end
        @(negedge clk);
      end
      $display("sweep: digit %0d code %b", d, code);
    end
  endtask

  initial begin
    last_code = 5'b00000;
    test_reset();
    test_first_frame();
    test_invalid();
    test_back_to_back();
    test_reset_mid_frame();
    test_one_clk();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
